// File: rtl/wb_sram_responder.sv
// Wishbone-style burst responder serving single-word and burst accesses from a
// single-port SRAM macro: one SRAM access and one registered ack pulse per beat.
module wb_sram_responder #(
  parameter int ADDR_LEN    = 32,
  parameter int WB_DATA_LEN = 32,
  parameter int MEM_IDX_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [ADDR_LEN-1:0]    wb_adr_i,
  input  logic [9:0]             wb_bl_i,
  input  logic                   wb_bry_i,
  input  logic [WB_DATA_LEN-1:0] wb_dat_i,
  output logic                   wb_ack_o,
  output logic [WB_DATA_LEN-1:0] wb_dat_o,
  output logic                   mem_chip_en,
  output logic                   mem_write_en,
  output logic [3:0]             mem_write_mask,
  output logic [MEM_IDX_W-1:0]   mem_index,
  output logic [WB_DATA_LEN-1:0] mem_data_in,
  input  logic [WB_DATA_LEN-1:0] mem_data_out
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_ACK       = 2'd2;
  localparam logic [1:0] S_WAIT_DROP = 2'd3;

  logic [1:0]           state;
  logic [9:0]           beat_cnt;
  logic [9:0]           bl_q;
  logic [MEM_IDX_W-1:0] base_idx;
  logic                 we_q;
  logic                 access;
  logic                 last_beat;
  logic                 unused_adr;

  // Only the word-index field of the byte address reaches the SRAM.
  assign unused_adr = ^{wb_adr_i[ADDR_LEN-1:MEM_IDX_W+2], wb_adr_i[1:0]};

  assign access    = (state == S_ISSUE) && wb_cyc_i && wb_bry_i;
  assign last_beat = (beat_cnt == bl_q - 10'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      bl_q     <= '0;
      base_idx <= '0;
      we_q     <= 1'b0;
      wb_ack_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            base_idx <= wb_adr_i[MEM_IDX_W+1:2];
            we_q     <= wb_we_i;
            bl_q     <= (wb_bl_i == 10'd0) ? 10'd1 : wb_bl_i;
            beat_cnt <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!wb_cyc_i) begin
            state <= S_IDLE;
          end else if (wb_bry_i) begin
            state    <= S_ACK;
            wb_ack_o <= 1'b1;
          end
        end
        S_ACK: begin
          beat_cnt <= beat_cnt + 10'd1;
          // Dropping cyc during the ack is normal completion or an abort.
          if (!wb_cyc_i) begin
            state <= S_IDLE;
          end else if (last_beat) begin
            state <= S_WAIT_DROP;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_WAIT_DROP: begin
          if (!wb_cyc_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_chip_en    = 1'b1;
    mem_write_en   = 1'b1;
    mem_write_mask = 4'b0000;
    mem_index      = '0;
    mem_data_in    = '0;
    if (access) begin
      mem_chip_en = 1'b0;
      mem_index   = base_idx + MEM_IDX_W'(beat_cnt);
      if (we_q) begin
        mem_write_en   = 1'b0;
        mem_write_mask = 4'b1111;
        mem_data_in    = wb_dat_i;
      end
    end
  end

  // Read data comes straight from the macro, which is valid in the ack cycle.
  always_comb begin
    wb_dat_o = '0;
    if (state == S_ACK && !we_q) begin
      wb_dat_o = mem_data_out;
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: table-driven transactions plus
// hand-written stall, abort and asynchronous-reset sequences.
module tb_wb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_bry_i;
  logic [31:0] wb_adr_i;
  logic [9:0]  wb_bl_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        mem_chip_en, mem_write_en;
  logic [3:0]  mem_write_mask;
  logic [7:0]  mem_index;
  logic [31:0] mem_data_in, mem_data_out;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  logic [31:0] sram [256];

  int          acc_cycle [$];
  logic [7:0]  acc_idx   [$];
  logic        acc_wen   [$];
  logic [3:0]  acc_mask  [$];
  logic [31:0] acc_din   [$];

  int          ack_cycle [16];
  logic [31:0] ack_data  [16];
  int          n_acks;
  int          txn_start;

  typedef struct {
    string            name;
    logic             we;
    logic [31:0]      adr;
    logic [9:0]       bl;
    logic [3:0][31:0] wdata;
    int               beats;
    logic [3:0][7:0]  idx;
    logic [3:0][31:0] rdata;
  } vec_t;

  vec_t vecs [5];

  wb_sram_responder #(.ADDR_LEN(32), .WB_DATA_LEN(32), .MEM_IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_bl_i(wb_bl_i), .wb_bry_i(wb_bry_i),
    .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .mem_chip_en(mem_chip_en), .mem_write_en(mem_write_en),
    .mem_write_mask(mem_write_mask), .mem_index(mem_index),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // SRAM macro model: registered read data, full-word writes.
  always @(posedge clk) begin
    if (!mem_chip_en) begin
      if (!mem_write_en) sram[mem_index] <= mem_data_in;
      mem_data_out <= sram[mem_index];
    end
  end

  // Access log, tagged with the label of the cycle the select was active in.
  always @(posedge clk) begin
    if (!mem_chip_en) begin
      acc_cycle.push_back(cycle_cnt);
      acc_idx.push_back(mem_index);
      acc_wen.push_back(mem_write_en);
      acc_mask.push_back(mem_write_mask);
      acc_din.push_back(mem_data_in);
    end
    cycle_cnt = cycle_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Initiator: drops cyc combinationally on the last (or abort) ack.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [9:0] bl,
                               input logic [3:0][31:0] wdata, input int stall, input int abort_after);
    int  eff;
    int  left;
    bit  done;
    acc_cycle.delete(); acc_idx.delete(); acc_wen.delete(); acc_mask.delete(); acc_din.delete();
    n_acks = 0;
    eff    = (bl == 10'd0) ? 1 : int'(bl);
    left   = 0;
    done   = 1'b0;
    txn_start = cycle_cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
    wb_bl_i = bl; wb_bry_i = 1'b1; wb_dat_i = wdata[0];
    @(posedge clk); #1;
    wb_stb_i = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      if (left > 0) begin
        left--;
        wb_bry_i = 1'b0;
      end else begin
        wb_bry_i = 1'b1;
      end
      if (wb_ack_o) begin
        if (n_acks < 16) begin
          ack_cycle[n_acks] = cycle_cnt;
          ack_data[n_acks]  = wb_dat_o;
        end
        n_acks++;
        wb_dat_i = (n_acks < 4) ? wdata[n_acks] : 32'h0;
        if (n_acks == eff || n_acks == abort_after) begin
          wb_cyc_i = 1'b0;
          done     = 1'b1;
        end else if (n_acks == 1 && stall > 0) begin
          left     = stall;
          wb_bry_i = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    checkOutput("txn_completed", {31'b0, done}, 32'd1);
    wb_cyc_i = 1'b0;
  endtask

  task automatic verifyTxn(input vec_t v);
    checkOutput({v.name, "_acks"}, n_acks, v.beats);
    checkOutput({v.name, "_accesses"}, acc_idx.size(), v.beats);
    for (int i = 0; i < v.beats && i < acc_idx.size(); i++) begin
      checkOutput($sformatf("%s_idx%0d", v.name, i), {24'b0, acc_idx[i]}, {24'b0, v.idx[i]});
      checkOutput($sformatf("%s_wen%0d", v.name, i), {31'b0, acc_wen[i]}, {31'b0, !v.we});
      if (v.we) begin
        checkOutput($sformatf("%s_mask%0d", v.name, i), {28'b0, acc_mask[i]}, 32'hF);
        checkOutput($sformatf("%s_din%0d", v.name, i), acc_din[i], v.wdata[i]);
      end
    end
    for (int i = 0; i < v.beats && i < n_acks && i < 16; i++) begin
      checkOutput($sformatf("%s_dat%0d", v.name, i), ack_data[i], v.we ? 32'h0 : v.rdata[i]);
      if (i == 0)
        checkOutput($sformatf("%s_lat", v.name), ack_cycle[0] - txn_start, 32'd2);
      else
        checkOutput($sformatf("%s_gap%0d", v.name, i), ack_cycle[i] - ack_cycle[i-1], 32'd2);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h10] = 32'hDEADBEEF;
    sram[8'h00] = 32'hA5A50000;
    sram[8'hFE] = 32'hFE00FE00;
    sram[8'hFF] = 32'hFF00FF00;
    sram[8'h01] = 32'h01010101;

    vecs[0] = '{"rd_single", 1'b0, 32'h40, 10'd1, '0, 1,
                {8'h0, 8'h0, 8'h0, 8'h10}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};
    vecs[1] = '{"wr_burst", 1'b1, 32'h100, 10'd4, {32'h44, 32'h33, 32'h22, 32'h11}, 4,
                {8'h43, 8'h42, 8'h41, 8'h40}, '0};
    vecs[2] = '{"rd_burst", 1'b0, 32'h100, 10'd4, '0, 4,
                {8'h43, 8'h42, 8'h41, 8'h40}, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[3] = '{"rd_bl0", 1'b0, 32'h0, 10'd0, '0, 1,
                {8'h0, 8'h0, 8'h0, 8'h00}, {32'h0, 32'h0, 32'h0, 32'hA5A50000}};
    vecs[4] = '{"rd_wrap", 1'b0, 32'h3F8, 10'd4, '0, 4,
                {8'h01, 8'h00, 8'hFF, 8'hFE},
                {32'h01010101, 32'hA5A50000, 32'hFF00FF00, 32'hFE00FE00}};

    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_bry_i = 1'b0;
    wb_adr_i = '0; wb_bl_i = '0; wb_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    checkOutput("rst_dat", wb_dat_o, 32'd0);
    checkOutput("rst_ce", {31'b0, mem_chip_en}, 32'd1);
    checkOutput("rst_we", {31'b0, mem_write_en}, 32'd1);
    checkOutput("rst_mask", {28'b0, mem_write_mask}, 32'd0);
    checkOutput("rst_idx", {24'b0, mem_index}, 32'd0);
    checkOutput("rst_din", mem_data_in, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].we, vecs[v].adr, vecs[v].bl, vecs[v].wdata, 0, 0);
      verifyTxn(vecs[v]);
    end

    // Stall: bry low for three cycles after the first ack.
    applyStimulus(1'b0, 32'h100, 10'd2, '0, 3, 0);
    checkOutput("stall_acks", n_acks, 32'd2);
    checkOutput("stall_accesses", acc_idx.size(), 32'd2);
    if (acc_idx.size() >= 2 && n_acks >= 2) begin
      checkOutput("stall_idx1", {24'b0, acc_idx[1]}, 32'h41);
      checkOutput("stall_acc_cycle", acc_cycle[1] - ack_cycle[0], 32'd4);
      checkOutput("stall_ack_cycle", ack_cycle[1] - ack_cycle[0], 32'd5);
      checkOutput("stall_dat0", ack_data[0], 32'h11);
      checkOutput("stall_dat1", ack_data[1], 32'h22);
    end

    // Abort: cyc dropped on the first of four acks.
    applyStimulus(1'b0, 32'h100, 10'd4, '0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_acks", n_acks, 32'd1);
    checkOutput("abort_accesses", acc_idx.size(), 32'd1);
    checkOutput("abort_dat0", ack_data[0], 32'h11);

    // Asynchronous reset while a read select is being driven.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h100;
    wb_bl_i = 10'd4; wb_bry_i = 1'b1;
    @(posedge clk); #1;
    wb_stb_i = 1'b0;
    checkOutput("pre_rst_ce", {31'b0, mem_chip_en}, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_ce", {31'b0, mem_chip_en}, 32'd1);
    checkOutput("async_rst_ack", {31'b0, wb_ack_o}, 32'd0);
    checkOutput("async_rst_idx", {24'b0, mem_index}, 32'd0);
    wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("post_rst_ack", {31'b0, wb_ack_o}, 32'd0);
    @(posedge clk); #1;

    applyStimulus(vecs[2].we, vecs[2].adr, vecs[2].bl, vecs[2].wdata, 0, 0);
    verifyTxn(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
